conv_mac_engine: RTL and testbench
==================================

Name: conv_mac_engine

Overview:
- Parametrised successor to the fixed squeeze-layer MAC blocks. One engine serves any conv/squeeze layer.
- DSP_NO parallel MACs each compute one output channel from a shared streamed input pixel.
- Adds over the fixed blocks:
  - valid/ready input handshake;
  - weight-ROM address generation aligned to the ROM latency;
  - back-to-back accumulation with no bubble;
  - signed rounding, saturation and optional ReLU;
  - a proper start/busy/done control FSM.
- Sits between the feature-map fetch logic and the per-layer output buffer; layer wrappers instantiate it with their own ROM and bias tables.

Parameters:
- DSP_NO, 16, number of parallel MACs / output channels per pass
- WIDTH, 16, signed fixed-point data width of ifm, weights, bias, ofm
- FRAC_BITS, 8, fractional bits of all WIDTH-wide operands
- CHIN, 64, input channels
- KERNEL_DIM, 3, square kernel side
- W_OUT, 64, output pixels per row
- H_OUT, 64, output rows
- RELU_EN, 1, 1 = clamp negative results to 0
- TAPS, CHIN*KERNEL_DIM**2 (derived), taps per output pixel
- ACC_W, 2*WIDTH+$clog2(TAPS) (derived), accumulator width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse, begins a layer pass
- ifm  in  WIDTH  input pixel tap, signed
- ifm_valid  in  1  ifm holds a valid tap
- ifm_ready  out  1  engine accepts a tap this cycle
- weight_addr  out  $clog2(TAPS)  weight ROM address
- weights  in  DSP_NO x WIDTH  ROM data, valid one cycle after weight_addr
- bias  in  DSP_NO x WIDTH  per-channel bias, static during a pass
- ofm  out  DSP_NO x WIDTH  output pixel, all channels
- ofm_valid  out  1  one-cycle pulse, ofm holds a new pixel
- busy  out  1  high in RUN and DRAIN
- done  out  1  layer finished; held until next start

Behaviour:
- Reset: FSM in IDLE; all counters, accumulators and ofm at 0; ofm_valid, busy, done, ifm_ready at 0; weight_addr 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start -> RUN. tap_cnt, pix_cnt and done clear.
  - RUN -> DRAIN on acceptance of the last tap of pixel W_OUT*H_OUT-1.
  - DRAIN -> DONE in the cycle the final ofm_valid is issued.
  - start in RUN or DRAIN is ignored.
- Handshake: ifm_ready = 1 only in RUN. A tap is accepted when ifm_valid && ifm_ready. Stalls of any length are legal; the pipeline holds no state beyond accepted taps.
- Addressing: weight_addr = tap_cnt (combinational). tap_cnt increments on accept and wraps TAPS-1 -> 0; on wrap pix_cnt increments.
- Pipeline:
  - Accept at edge t registers ifm and a first/last tag.
  - At edge t+1 each MAC forms weights[i]*ifm_reg (signed, 2*WIDTH). A first-tap product loads the accumulator; any other tap adds to it. No clear bubble between pixels.
  - Last-tap tag at edge t+2 writes ofm and raises ofm_valid for exactly one cycle. Last-tap latency is 2 cycles after accept.
- Output arithmetic per channel:
  - s = acc + (sign-extended bias << FRAC_BITS)
  - r = (s + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift, round half up
  - Saturate r to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If RELU_EN and r < 0, ofm = 0.
- ofm holds its value between pulses. It is not cleared at start.
- Bubble taps (ifm_valid low) do not touch accumulators.
- Async reset mid-pass returns to IDLE immediately; the partial pixel is discarded and no ofm_valid is issued.
- done drops in the cycle after start is sampled in DONE.

Decomposition:
- Package conv_pkg:
  - function acc_width(taps, width);
  - function sat_round(acc, frac_bits, width, relu);
  - typedef enum {IDLE, RUN, DRAIN, DONE} conv_state_t.
- Sub-module mac_lane: registered multiply plus load/accumulate; ports clk, rst, load, en, pix, ker, acc. Instantiated DSP_NO times by generate.
- Rounding/saturation stays in the top level via the package function.

Test Plan:
Common bench parameters: DSP_NO=2, WIDTH=16, FRAC_BITS=8, CHIN=2, KERNEL_DIM=1, W_OUT=H_OUT=2 (TAPS=2, 4 pixels).
1. Weights all 0x0100, ifm 0x0100 continuous, bias 0 -> four ofm_valid pulses spaced 2 cycles apart; ofm={0x0200,0x0200}; done 2 cycles after the 8th accept.
2. Same stimulus, ifm_valid toggled 1/0 -> identical ofm values; weight_addr advances only on accepts; ofm_valid spacing 4 cycles.
3. Weights {0x0100, 0xFF00}, ifm 0x0300, bias {0x0080, 0}, RELU_EN=1 -> ofm={0x0680, 0x0000}. Repeat with RELU_EN=0 -> ch1=0xFA00.
4. Weights 0x7FFF, ifm 0x7FFF -> ofm saturates to 0x7FFF. Both operands 0x8000 with weight 0x7FFF and RELU_EN=0 -> 0x8000.
5. Reset asserted after the 1st tap of pixel 2 -> outputs 0 immediately, no further ofm_valid. New start -> full 4-pixel pass, results as in scenario 1.
6. start pulsed during RUN -> ignored, pixel count unaffected. start in DONE -> done low next cycle, new pass runs.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type and arithmetic helpers for the conv MAC engine
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    // Wide enough for any accumulator plus a shifted bias in supported configurations
    localparam int SUM_W = 64;

    function automatic int acc_width(input int taps, input int width);
        return 2 * width + $clog2(taps);
    endfunction

    // Round half up at the binary point, then clamp to the signed output range
    function automatic logic signed [SUM_W-1:0] sat_round(
        input logic signed [SUM_W-1:0] acc,
        input int                      frac_bits,
        input int                      width,
        input logic                    relu
    );
        logic signed [SUM_W-1:0] half;
        logic signed [SUM_W-1:0] r;
        logic signed [SUM_W-1:0] max_v;
        logic signed [SUM_W-1:0] min_v;
        half  = 64'sd1 <<< (frac_bits - 1);
        r     = (acc + half) >>> frac_bits;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end
        if (relu && (r < 0)) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one output channel: signed multiply with load/accumulate
module mac_lane #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 38
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] pix,
    input  logic signed [WIDTH-1:0] ker,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;

    assign prod     = pix * ker;
    assign prod_ext = ACC_W'(prod);

    // First tap of a pixel overwrites the sum, so consecutive pixels need no clear cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= load ? prod_ext : acc + prod_ext;
        end
    end

endmodule

// File: rtl/conv_mac_engine.sv
// rtl/conv_mac_engine.sv - parametrised multi-channel conv MAC engine with handshake and control FSM
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int DSP_NO     = 16,
    parameter int WIDTH      = 16,
    parameter int FRAC_BITS  = 8,
    parameter int CHIN       = 64,
    parameter int KERNEL_DIM = 3,
    parameter int W_OUT      = 64,
    parameter int H_OUT      = 64,
    parameter int RELU_EN    = 1,
    localparam int TAPS      = CHIN * KERNEL_DIM * KERNEL_DIM,
    localparam int ACC_W     = acc_width(TAPS, WIDTH),
    localparam int AW        = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             ifm,
    input  logic                         ifm_valid,
    output logic                         ifm_ready,
    output logic [AW-1:0]                weight_addr,
    input  logic [DSP_NO-1:0][WIDTH-1:0] weights,
    input  logic [DSP_NO-1:0][WIDTH-1:0] bias,
    output logic [DSP_NO-1:0][WIDTH-1:0] ofm,
    output logic                         ofm_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int NPIX = W_OUT * H_OUT;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    conv_state_t state;
    conv_state_t state_nxt;

    logic [AW-1:0]           tap_cnt;
    logic [PW-1:0]           pix_cnt;
    logic                    accept;
    logic                    start_go;
    logic                    tap_last;
    logic                    pix_last;

    logic signed [WIDTH-1:0] ifm_reg;
    logic                    s1_valid;
    logic                    s1_first;
    logic                    s1_last;
    logic                    s2_last;

    logic signed [ACC_W-1:0]       acc [DSP_NO];
    logic signed [SUM_W-1:0]       sum [DSP_NO];
    logic [DSP_NO-1:0][WIDTH-1:0]  ofm_nxt;

    assign ifm_ready   = (state == RUN);
    assign accept      = ifm_valid && ifm_ready;
    assign start_go    = start && ((state == IDLE) || (state == DONE));
    assign tap_last    = (tap_cnt == AW'(TAPS - 1));
    assign pix_last    = (pix_cnt == PW'(NPIX - 1));
    assign weight_addr = tap_cnt;
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);

    // Control state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: DRAIN ends on the edge that issues the final ofm_valid
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && tap_last && pix_last) state_nxt = DRAIN;
            DRAIN:   if (s2_last) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Tap/pixel counters; tap_cnt doubles as the weight ROM address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap_cnt <= '0;
            pix_cnt <= '0;
        end else if (start_go) begin
            tap_cnt <= '0;
            pix_cnt <= '0;
        end else if (accept) begin
            if (tap_last) begin
                tap_cnt <= '0;
                pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
            end else begin
                tap_cnt <= tap_cnt + 1'b1;
            end
        end
    end

    // Capture accepted tap and its position tags; ROM data arrives one cycle later to meet it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifm_reg  <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                ifm_reg  <= $signed(ifm);
                s1_first <= (tap_cnt == '0);
                s1_last  <= tap_last;
            end
            s2_last <= s1_valid && s1_last;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DSP_NO; g++) begin : g_lane
            mac_lane #(
                .WIDTH (WIDTH),
                .ACC_W (ACC_W)
            ) u_lane (
                .clk  (clk),
                .rst  (rst),
                .load (s1_first),
                .en   (s1_valid),
                .pix  (ifm_reg),
                .ker  (weights[g]),
                .acc  (acc[g])
            );
        end
    endgenerate

    // Bias add aligned to the product binary point, then round/saturate/ReLU
    always_comb begin
        ofm_nxt = '0;
        for (int i = 0; i < DSP_NO; i++) begin
            sum[i]     = SUM_W'(acc[i]) + (SUM_W'($signed(bias[i])) <<< FRAC_BITS);
            ofm_nxt[i] = WIDTH'(sat_round(sum[i], FRAC_BITS, WIDTH, RELU_EN != 0));
        end
    end

    // Output register: written only on the last-tap tag, held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ofm       <= '0;
            ofm_valid <= 1'b0;
        end else begin
            ofm_valid <= s2_last;
            if (s2_last) begin
                ofm <= ofm_nxt;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb/tb_conv_mac_engine.sv - self-checking bench for conv_mac_engine
module tb_conv_mac_engine;

    localparam int DSP_NO = 2;
    localparam int TAPS   = 2;
    localparam int NPIX   = 4;
    localparam int NTAP   = TAPS * NPIX;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [15:0] ifm;
    logic ifm_valid;
    logic [1:0][15:0] bias;

    logic ifm_ready0, ifm_ready1;
    logic [0:0] waddr0, waddr1;
    logic [1:0][15:0] weights0, weights1, ofm0, ofm1;
    logic ofm_valid0, ofm_valid1, busy0, busy1, done0, done1;

    logic [15:0] rom_w [TAPS][DSP_NO];
    logic [15:0] xs [NTAP];
    logic [15:0] exp_r0 [NPIX][DSP_NO];
    logic [15:0] exp_r1 [NPIX][DSP_NO];

    typedef struct {
        int          cy;
        logic [15:0] c0;
        logic [15:0] c1;
    } pulse_t;
    pulse_t cap0[$];
    pulse_t cap1[$];
    int     acc_cy[$];

    typedef struct {
        logic [15:0] w0, w1, x, b0, b1;
        int          gap;
        logic [15:0] r0c0, r0c1, r1c0, r1c1;
        int          spacing;
    } vec_t;
    vec_t vecs[6];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int c = 0; c < DSP_NO; c++) begin
            weights0[c] <= rom_w[waddr0][c];
            weights1[c] <= rom_w[waddr1][c];
        end
    end

    always @(negedge clk) begin : monitor
        pulse_t p;
        if (ofm_valid0) begin
            p.cy = cyc; p.c0 = ofm0[0]; p.c1 = ofm0[1];
            cap0.push_back(p);
        end
        if (ofm_valid1) begin
            p.cy = cyc; p.c0 = ofm1[0]; p.c1 = ofm1[1];
            cap1.push_back(p);
        end
    end

    conv_mac_engine #(
        .DSP_NO(2), .WIDTH(16), .FRAC_BITS(8), .CHIN(2), .KERNEL_DIM(1),
        .W_OUT(2), .H_OUT(2), .RELU_EN(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .ifm(ifm), .ifm_valid(ifm_valid),
        .ifm_ready(ifm_ready0), .weight_addr(waddr0), .weights(weights0), .bias(bias),
        .ofm(ofm0), .ofm_valid(ofm_valid0), .busy(busy0), .done(done0)
    );

    conv_mac_engine #(
        .DSP_NO(2), .WIDTH(16), .FRAC_BITS(8), .CHIN(2), .KERNEL_DIM(1),
        .W_OUT(2), .H_OUT(2), .RELU_EN(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .ifm(ifm), .ifm_valid(ifm_valid),
        .ifm_ready(ifm_ready1), .weight_addr(waddr1), .weights(weights1), .bias(bias),
        .ofm(ofm1), .ofm_valid(ofm_valid1), .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: exact integer dot product, floor-divided after adding half an LSB
    function automatic logic [15:0] model_pix(input int p, input int ch, input bit relu);
        longint s;
        longint q;
        s = 0;
        for (int t = 0; t < TAPS; t++)
            s += longint'($signed(rom_w[t][ch])) * longint'($signed(xs[p*TAPS+t]));
        s += longint'($signed(bias[ch])) * 256;
        s += 128;
        q = s / 256;
        if (s < 0 && q * 256 != s) q -= 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        if (relu && q < 0) q = 0;
        return 16'(q);
    endfunction

    function automatic logic [15:0] rnd_val();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 2047)) - 16'd1024;
    endfunction

    // Pulse start, then feed taps with the chosen valid pattern; start is re-asserted at tap start_at
    task automatic drive_pass(input int gap_mode, input int start_at, input int stop_after);
        int   n;
        int   guard;
        logic v;
        n = 0;
        guard = 0;
        acc_cy.delete();
        cap0.delete();
        cap1.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_taken", {done0, done1, busy0, busy1, ifm_ready0, ifm_ready1}, 64'b001111);
        while (n < stop_after && guard < 400) begin
            guard++;
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 1);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            ifm_valid = v;
            ifm       = v ? xs[n] : 16'($urandom);
            start     = (n == start_at);
            if (v && ifm_ready1) begin
                check("weight_addr", {waddr0, waddr1}, {1'(n % TAPS), 1'(n % TAPS)});
                acc_cy.push_back(cyc + 1);
                n++;
            end
            @(negedge clk);
        end
        ifm_valid = 1'b0;
        start     = 1'b0;
        if (guard >= 400) begin
            tests++;
            fails++;
            $display("FAIL drive_timeout: accepted %0d taps, required %0d", n, stop_after);
        end
    endtask

    task automatic check_pass(input string tag, input int spacing);
        int g;
        g = 0;
        while (!(done0 && done1) && g < 60) begin
            @(negedge clk);
            g++;
        end
        tests++;
        if (g >= 60) begin
            fails++;
            $display("FAIL %s_done_timeout: done=%b%b, required 11", tag, done0, done1);
        end
        if (acc_cy.size() == NTAP)
            check({tag, "_done_latency"}, 64'(cyc), 64'(acc_cy[NTAP-1] + 2));
        repeat (3) @(negedge clk);
        check({tag, "_done_held"}, {done0, done1, busy0, busy1}, 64'b1100);
        check({tag, "_pulses_r0"}, 64'(cap0.size()), 64'(NPIX));
        check({tag, "_pulses_r1"}, 64'(cap1.size()), 64'(NPIX));
        for (int p = 0; p < NPIX && p < cap0.size() && p < cap1.size(); p++) begin
            check($sformatf("%s_pix%0d_relu0", tag, p), {cap0[p].c1, cap0[p].c0},
                  {exp_r0[p][1], exp_r0[p][0]});
            check($sformatf("%s_pix%0d_relu1", tag, p), {cap1[p].c1, cap1[p].c0},
                  {exp_r1[p][1], exp_r1[p][0]});
            if (acc_cy.size() == NTAP)
                check($sformatf("%s_pix%0d_latency", tag, p), 64'(cap1[p].cy),
                      64'(acc_cy[p*TAPS+TAPS-1] + 2));
            if (spacing > 0 && p > 0)
                check($sformatf("%s_pix%0d_spacing", tag, p), 64'(cap1[p].cy - cap1[p-1].cy),
                      64'(spacing));
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int t = 0; t < TAPS; t++) begin
            rom_w[t][0] = v.w0;
            rom_w[t][1] = v.w1;
        end
        for (int n = 0; n < NTAP; n++) xs[n] = v.x;
        bias[0] = v.b0;
        bias[1] = v.b1;
        for (int p = 0; p < NPIX; p++) begin
            exp_r0[p][0] = v.r0c0; exp_r0[p][1] = v.r0c1;
            exp_r1[p][0] = v.r1c0; exp_r1[p][1] = v.r1c1;
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; ifm_valid = 1'b0; ifm = '0; bias = '0;
        for (int t = 0; t < TAPS; t++) for (int c = 0; c < DSP_NO; c++) rom_w[t][c] = '0;
        for (int n = 0; n < NTAP; n++) xs[n] = '0;

        vecs[0] = '{16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 0,
                    16'h0200, 16'h0200, 16'h0200, 16'h0200, 2};
        vecs[1] = '{16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1,
                    16'h0200, 16'h0200, 16'h0200, 16'h0200, 4};
        vecs[2] = '{16'h0100, 16'hFF00, 16'h0300, 16'h0080, 16'h0000, 0,
                    16'h0680, 16'hFA00, 16'h0680, 16'h0000, 2};
        vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 0,
                    16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 2};
        vecs[4] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 0,
                    16'h8000, 16'h7FFF, 16'h0000, 16'h7FFF, 2};
        vecs[5] = '{16'h0040, 16'hFFBF, 16'h0001, 16'h0000, 16'h0000, 0,
                    16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 2};

        repeat (3) @(negedge clk);
        check("reset_ofm", {ofm0, ofm1}, 64'h0);
        check("reset_ctrl", {ofm_valid0, ofm_valid1, busy0, busy1, done0, done1,
                             ifm_ready0, ifm_ready1}, 64'h0);
        check("reset_addr", {waddr0, waddr1}, 64'h0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            load_vec(vecs[i]);
            drive_pass(vecs[i].gap, -1, NTAP);
            check_pass($sformatf("vec%0d", i), vecs[i].spacing);
        end

        // Reset after the first tap of the third pixel
        load_vec(vecs[0]);
        drive_pass(0, -1, 5);
        rst = 1'b0;
        #1;
        check("midreset_ofm", {ofm0, ofm1}, 64'h0);
        check("midreset_ctrl", {ofm_valid0, ofm_valid1, busy0, busy1, done0, done1,
                                ifm_ready0, ifm_ready1}, 64'h0);
        check("midreset_addr", {waddr0, waddr1}, 64'h0);
        cap0.delete();
        cap1.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("midreset_no_pulse", 64'(cap0.size() + cap1.size()), 64'h0);
        drive_pass(0, -1, NTAP);
        check_pass("after_reset", 2);

        // start during RUN must not disturb the pass
        drive_pass(0, 3, NTAP);
        check_pass("start_in_run", 2);

        // Randomised passes against the reference model
        for (int r = 0; r < 8; r++) begin
            for (int t = 0; t < TAPS; t++) for (int c = 0; c < DSP_NO; c++) rom_w[t][c] = rnd_val();
            for (int n = 0; n < NTAP; n++) xs[n] = rnd_val();
            bias[0] = rnd_val();
            bias[1] = rnd_val();
            for (int p = 0; p < NPIX; p++) begin
                for (int c = 0; c < DSP_NO; c++) begin
                    exp_r0[p][c] = model_pix(p, c, 1'b0);
                    exp_r1[p][c] = model_pix(p, c, 1'b1);
                end
            end
            drive_pass(2, -1, NTAP);
            check_pass($sformatf("rand%0d", r), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
